ddr_ex_test_sequencer: RTL and testbench

Sequencer for the DDR example driver. It runs one pattern test per `start` pulse:
- loads a seed into two external 8-bit LFSRs (write generator, read checker);
- writes the write-LFSR sequence to addresses 0..LAST_ADDR;
- reads the same range back;
- compares each returned word against the checker-LFSR sequence.

It sits between the local (user-side) memory controller interface and the two LFSR instances, driving their enable/pause/load controls.

---
 rtl/ddr_ex_test_sequencer.sv | 142 ++++++++++++++
 tb/tb_ddr_ex_test_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ex_test_sequencer.sv
// Pattern-test sequencer for the DDR example driver. It seeds two external LFSRs,
// writes the generator sequence over 0..LAST_ADDR, reads it back and counts mismatches.
module ddr_ex_test_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        seed_in,
  input  logic              local_ready,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic [ADDR_W-1:0] local_addr,
  output logic [7:0]        local_wdata,
  input  logic [7:0]        local_rdata,
  input  logic              local_rdata_valid,
  output logic              wr_lfsr_enable,
  output logic              wr_lfsr_pause,
  output logic              wr_lfsr_load,
  output logic [7:0]        wr_lfsr_ldata,
  input  logic [7:0]        wr_lfsr_data,
  output logic              rd_lfsr_enable,
  output logic              rd_lfsr_pause,
  output logic              rd_lfsr_load,
  output logic [7:0]        rd_lfsr_ldata,
  input  logic [7:0]        rd_lfsr_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_READ,
    S_WAIT_RD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W:0]   RCV_TOTAL = (ADDR_W + 1)'(LAST_ADDR + 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W:0]     rcv_cnt_reg, rcv_cnt_next;
  logic [7:0]          err_cnt_reg, err_cnt_next;
  logic                rx_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      rcv_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      rcv_cnt_reg <= rcv_cnt_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign rx_active = (state_reg == S_READ) || (state_reg == S_WAIT_RD);

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    rcv_cnt_next    = rcv_cnt_reg;
    err_cnt_next    = err_cnt_reg;
    local_write_req = 1'b0;
    local_read_req  = 1'b0;
    wr_lfsr_pause   = 1'b1;
    rd_lfsr_pause   = 1'b1;
    wr_lfsr_load    = 1'b0;
    rd_lfsr_load    = 1'b0;

    // Returns only count while a read-back is in progress; strays elsewhere are dropped.
    if (rx_active && local_rdata_valid) begin
      rd_lfsr_pause = 1'b0;
      rcv_cnt_next  = rcv_cnt_reg + 1'b1;
      if ((local_rdata != rd_lfsr_data) && (err_cnt_reg != 8'hFF))
        err_cnt_next = err_cnt_reg + 8'd1;
    end

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next   = S_LOAD;
          addr_next    = '0;
          rcv_cnt_next = '0;
          err_cnt_next = '0;
        end
      end
      S_LOAD: begin
        wr_lfsr_load = 1'b1;
        rd_lfsr_load = 1'b1;
        state_next   = S_WRITE;
      end
      S_WRITE: begin
        local_write_req = 1'b1;
        if (local_ready) begin
          wr_lfsr_pause = 1'b0;
          if (addr_reg == LAST_A) begin
            addr_next  = '0;
            state_next = S_READ;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      S_READ: begin
        local_read_req = 1'b1;
        if (local_ready) begin
          addr_next = addr_reg + 1'b1;
          if (addr_reg == LAST_A)
            state_next = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (rcv_cnt_reg == RCV_TOTAL)
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign local_addr     = addr_reg;
  assign local_wdata    = wr_lfsr_data;
  assign wr_lfsr_ldata  = seed_in;
  assign rd_lfsr_ldata  = seed_in;
  assign wr_lfsr_enable = (state_reg != S_IDLE);
  assign rd_lfsr_enable = (state_reg != S_IDLE);
  assign busy           = (state_reg == S_LOAD) || (state_reg == S_WRITE) ||
                          (state_reg == S_READ) || (state_reg == S_WAIT_RD);
  assign done           = (state_reg == S_DONE);
  assign pass           = (state_reg == S_DONE) && (err_cnt_reg == 8'd0);
  assign err_cnt        = err_cnt_reg;

endmodule

// File: tb/tb_ddr_ex_test_sequencer.sv
// Bench for ddr_ex_test_sequencer: behavioural LFSRs and memory around the DUT, plus a
// transaction-level model (expected sequences, counts, error totals) checked every cycle.
module tb_ddr_ex_test_sequencer;

  localparam int ADDR_W    = 8;
  localparam int LAST_ADDR = 255;
  localparam int N         = LAST_ADDR + 1;
  localparam logic [7:0] WR_SEED_PARAM = 8'hA5;
  localparam logic [7:0] RD_SEED_PARAM = 8'h3C;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        seed_in = 8'h00;
  logic              local_ready = 1'b0;
  logic              local_write_req, local_read_req;
  logic [ADDR_W-1:0] local_addr;
  logic [7:0]        local_wdata;
  logic [7:0]        local_rdata = 8'h00;
  logic              local_rdata_valid = 1'b0;
  logic              wr_lfsr_enable, wr_lfsr_pause, wr_lfsr_load;
  logic [7:0]        wr_lfsr_ldata, wr_lfsr_data;
  logic              rd_lfsr_enable, rd_lfsr_pause, rd_lfsr_load;
  logic [7:0]        rd_lfsr_ldata, rd_lfsr_data;
  logic              busy, done, pass;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  ddr_ex_test_sequencer #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
    .local_ready(local_ready), .local_write_req(local_write_req),
    .local_read_req(local_read_req), .local_addr(local_addr),
    .local_wdata(local_wdata), .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid),
    .wr_lfsr_enable(wr_lfsr_enable), .wr_lfsr_pause(wr_lfsr_pause),
    .wr_lfsr_load(wr_lfsr_load), .wr_lfsr_ldata(wr_lfsr_ldata),
    .wr_lfsr_data(wr_lfsr_data),
    .rd_lfsr_enable(rd_lfsr_enable), .rd_lfsr_pause(rd_lfsr_pause),
    .rd_lfsr_load(rd_lfsr_load), .rd_lfsr_ldata(rd_lfsr_ldata),
    .rd_lfsr_data(rd_lfsr_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Galois LFSR, polynomial x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[7] ? ({v[6:0], 1'b0} ^ 8'h1D) : {v[6:0], 1'b0};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!wr_lfsr_enable)   wr_lfsr_data <= WR_SEED_PARAM;
    else if (wr_lfsr_load) wr_lfsr_data <= wr_lfsr_ldata;
    else if (!wr_lfsr_pause) wr_lfsr_data <= lfsr_step(wr_lfsr_data);
  end

  always @(posedge clk) begin
    if (!rd_lfsr_enable)   rd_lfsr_data <= RD_SEED_PARAM;
    else if (rd_lfsr_load) rd_lfsr_data <= rd_lfsr_ldata;
    else if (!rd_lfsr_pause) rd_lfsr_data <= lfsr_step(rd_lfsr_data);
  end

  // Memory environment controls (written only by the stimulus block)
  int ready_mode   = 0;   // 0: always ready, 1: toggle, 2: random
  int lat          = 1;
  int corrupt_addr = -1;
  bit corrupt_all  = 1'b0;
  int stray_ask    = 0;
  int stray_done   = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } ret_t;
  ret_t retq[$];
  logic [7:0] mem [N];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       local_ready = 1'b1;
      1:       local_ready = ~local_ready;
      default: local_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (retq.size() > 0 && retq[0].due <= cyc) begin
      local_rdata_valid = 1'b1;
      local_rdata       = retq[0].data;
      void'(retq.pop_front());
    end else if (stray_ask != stray_done) begin
      local_rdata_valid = 1'b1;
      local_rdata       = 8'($urandom);
      stray_done++;
    end else begin
      local_rdata_valid = 1'b0;
      local_rdata       = 8'($urandom);
    end
  end

  // Transaction-level reference model
  typedef enum {M_IDLE, M_LOAD, M_WRITE, M_READ, M_WAIT, M_DONE} mphase_t;
  mphase_t    ph = M_IDLE;
  int         wr_n = 0, rd_n = 0, rcv_n = 0, err_m = 0;
  int         last_ret_cyc = -1;
  logic       prev_done = 1'b0;
  logic [7:0] seq [N];
  logic [7:0] wlog [4];

  always @(negedge clk) begin
    logic    wacc, racc, rx;
    logic [7:0] mask;
    ret_t    r;
    mphase_t nph;
    if (reset) begin
      ph = M_IDLE; wr_n = 0; rd_n = 0; rcv_n = 0; err_m = 0;
    end
    wacc = (ph == M_WRITE) && local_ready;
    racc = (ph == M_READ) && local_ready;
    rx   = (ph == M_READ || ph == M_WAIT) && local_rdata_valid;

    check("write_req", local_write_req, ph == M_WRITE);
    check("read_req", local_read_req, ph == M_READ);
    check("busy", busy, ph inside {M_LOAD, M_WRITE, M_READ, M_WAIT});
    check("done", done, ph == M_DONE);
    check("err_cnt", err_cnt, err_m);
    check("enables", {wr_lfsr_enable, rd_lfsr_enable}, (ph != M_IDLE) ? 2'b11 : 2'b00);
    check("loads", {wr_lfsr_load, rd_lfsr_load}, (ph == M_LOAD) ? 2'b11 : 2'b00);
    check("ldata", {wr_lfsr_ldata, rd_lfsr_ldata}, {seed_in, seed_in});
    check("wdata_path", local_wdata, wr_lfsr_data);
    check("wr_pause", wr_lfsr_pause, !wacc);
    check("rd_pause", rd_lfsr_pause, !rx);
    if (ph == M_DONE) check("pass", pass, err_m == 0);
    if (ph == M_WRITE) begin
      check("wr_addr", local_addr, wr_n);
      check("wr_data", local_wdata, seq[wr_n]);
    end
    if (ph == M_READ) check("rd_addr", local_addr, rd_n);
    if (rx && rcv_n < N) check("checker_align", rd_lfsr_data, seq[rcv_n]);
    if (done && !prev_done && last_ret_cyc >= 0)
      check("done_latency", cyc - last_ret_cyc, 2);
    prev_done = done;

    if (!reset) begin
      nph = ph;
      case (ph)
        M_IDLE, M_DONE: if (start) begin
          nph = M_LOAD; wr_n = 0; rd_n = 0; rcv_n = 0; err_m = 0; last_ret_cyc = -1;
          seq[0] = seed_in;
          for (int i = 1; i < N; i++) seq[i] = lfsr_step(seq[i-1]);
        end
        M_LOAD: nph = M_WRITE;
        M_WRITE: if (wacc) begin
          if (wr_n < 4) wlog[wr_n] = local_wdata;
          mem[local_addr] = local_wdata;
          wr_n++;
          if (wr_n == N) nph = M_READ;
        end
        M_READ: if (racc) begin
          mask = (corrupt_all || int'(local_addr) == corrupt_addr) ? 8'hFF : 8'h00;
          r.due  = cyc + lat;
          r.data = mem[local_addr] ^ mask;
          retq.push_back(r);
          rd_n++;
          if (rd_n == N) nph = M_WAIT;
        end
        M_WAIT: if (rcv_n == N) nph = M_DONE;
        default: nph = M_IDLE;
      endcase
      if (rx && rcv_n < N) begin
        if (local_rdata != seq[rcv_n]) err_m = (err_m < 255) ? err_m + 1 : 255;
        rcv_n++;
        last_ret_cyc = cyc;
      end
      ph = nph;
    end
  end

  task automatic pulse_start(input logic [7:0] seed);
    seed_in = seed;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, {local_write_req, local_read_req, busy, done, pass,
                           wr_lfsr_enable, rd_lfsr_enable, wr_lfsr_load, rd_lfsr_load,
                           wr_lfsr_pause, rd_lfsr_pause}, 11'b00000000011);
    check({tag, "_err"}, err_cnt, 8'd0);
  endtask

  task automatic run_test(input string name, input logic [7:0] seed, input bit busy_start,
                          input int exp_err, input bit exp_pass);
    int k;
    pulse_start(seed);
    check({name, "_lat_load"}, {local_write_req, wr_lfsr_load, rd_lfsr_load}, 3'b011);
    @(posedge clk); #1;
    check({name, "_lat_write"}, {local_write_req, local_wdata}, {1'b1, seed});
    if (busy_start) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    k = 0;
    while (!done && k < 5000) begin @(posedge clk); #1; k++; end
    check({name, "_done"}, done, 1'b1);
    check({name, "_err_final"}, err_cnt, exp_err);
    check({name, "_pass_final"}, pass, exp_pass);
    $display("%s: seed=0x%02h err_cnt=%0d pass=%0b", name, seed, err_cnt, pass);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_test("seed01", 8'h01, 1'b0, 0, 1'b1);
    check("seed01_w0", wlog[0], 8'h01);
    check("seed01_w1", wlog[1], 8'h02);
    check("seed01_w2", wlog[2], 8'h04);
    check("seed01_w3", wlog[3], 8'h08);

    run_test("seed80", 8'h80, 1'b0, 0, 1'b1);
    check("seed80_w0", wlog[0], 8'h80);
    check("seed80_w1", wlog[1], 8'h1D);

    ready_mode = 1;
    run_test("toggle", 8'($urandom_range(1, 255)), 1'b1, 0, 1'b1);

    ready_mode = 2; corrupt_addr = 2;
    run_test("corrupt2", 8'($urandom_range(1, 255)), 1'b0, 1, 1'b0);

    corrupt_addr = -1; corrupt_all = 1'b1;
    run_test("saturate", 8'($urandom_range(1, 255)), 1'b0, 255, 1'b0);

    corrupt_all = 1'b0; lat = 5;
    stray_ask++;
    repeat (4) @(posedge clk);
    #1;
    run_test("latency5", 8'($urandom_range(1, 255)), 1'b0, 0, 1'b1);

    corrupt_all = 1'b1;
    pulse_start(8'hC3);
    k = 0;
    while (!local_read_req && k < 3000) begin @(posedge clk); #1; k++; end
    check("abort_reach_read", local_read_req, 1'b1);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_values("abort");
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    corrupt_all = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    run_test("rerun55", 8'h55, 1'b0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
